// File: rtl/ppm_frame_ctrl.sv
// ppm_frame_ctrl: frame controller sitting behind a 2-bit PPM symbol decoder.
// Assembles four symbols (MSB first) into a byte, counts bytes per frame and
// reports frame completion or the cause of an abort.
//
// Optional feature: define PPM_FRAME_TIMEOUT_EN to abort a frame after
// TIMEOUT_CYC clk cycles in ACTIVE without a sof_rcv or sym_valid.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   sof_rcv    start-of-frame pulse
//   eof_rcv    end-of-frame pulse
//   sym_valid  decoded symbol strobe
//   sym_data   decoded 2-bit symbol
//   dec_en     decoder enable, high only in ACTIVE
//   Dout       last assembled byte, held between D_en pulses
//   D_en       new-byte pulse
//   F_en       good-frame pulse
//   byte_cnt   bytes delivered in the current/last frame
//   frame_err  abort pulse
//   err_code   last abort cause: 01 overflow, 10 partial/empty, 11 timeout
module ppm_frame_ctrl #(
  parameter int unsigned MAX_BYTES   = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sof_rcv,
  input  logic       eof_rcv,
  input  logic       sym_valid,
  input  logic [1:0] sym_data,
  output logic       dec_en,
  output logic [7:0] Dout,
  output logic       D_en,
  output logic       F_en,
  output logic [7:0] byte_cnt,
  output logic       frame_err,
  output logic [1:0] err_code
);

  if (MAX_BYTES < 1 || MAX_BYTES > 255) begin : gen_max_bytes_chk
    $error("MAX_BYTES out of range 1..255");
  end
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : gen_timeout_chk
    $error("TIMEOUT_CYC out of range 2..65535");
  end

  typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

  localparam logic [1:0] ErrOvf     = 2'b01;
  localparam logic [1:0] ErrPartial = 2'b10;
  localparam logic [1:0] ErrTimeout = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [5:0]  shift_q, shift_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        d_en_q, d_en_d;
  logic        f_en_q, f_en_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  // Set when a byte-completing symbol and a good EOF coincide: D_en goes out
  // first, F_en one cycle later.
  logic        f_pend_q, f_pend_d;
  logic        ovf;
`ifdef PPM_FRAME_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    shift_d  = shift_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    d_en_d   = 1'b0;
    f_en_d   = f_pend_q;
    err_d    = 1'b0;
    code_d   = code_q;
    f_pend_d = 1'b0;
    ovf      = 1'b0;
`ifdef PPM_FRAME_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (sof_rcv) begin
          state_d = StActive;
          cnt_d   = 8'd0;
          phase_d = 2'd0;
`ifdef PPM_FRAME_TIMEOUT_EN
          tmo_d   = 16'd0;
`endif
        end
      end
      StActive: begin
`ifdef PPM_FRAME_TIMEOUT_EN
        tmo_d = tmo_q + 16'd1;
`endif
        if (sof_rcv) begin
          // Silent restart; wins over a simultaneous EOF.
          cnt_d   = 8'd0;
          phase_d = 2'd0;
`ifdef PPM_FRAME_TIMEOUT_EN
          tmo_d   = 16'd0;
`endif
        end else begin
          if (sym_valid) begin
`ifdef PPM_FRAME_TIMEOUT_EN
            tmo_d   = 16'd0;
`endif
            phase_d = phase_q + 2'd1;
            shift_d = {shift_q[3:0], sym_data};
            if (phase_q == 2'd3) begin
              if (cnt_q == 8'(MAX_BYTES)) begin
                ovf = 1'b1;
              end else begin
                dout_d = {shift_q, sym_data};
                cnt_d  = cnt_q + 8'd1;
                d_en_d = 1'b1;
              end
            end
          end
          // EOF is judged on the phase/count after this cycle's symbol.
          if (ovf) begin
            err_d   = 1'b1;
            code_d  = ErrOvf;
            state_d = eof_rcv ? StIdle : StDrain;
          end else if (eof_rcv) begin
            state_d = StIdle;
            if (phase_d == 2'd0 && cnt_d != 8'd0) begin
              if (d_en_d) f_pend_d = 1'b1;
              else        f_en_d   = 1'b1;
            end else begin
              err_d  = 1'b1;
              code_d = ErrPartial;
            end
          end
`ifdef PPM_FRAME_TIMEOUT_EN
          else if (!sym_valid && tmo_q == 16'(TIMEOUT_CYC - 1)) begin
            err_d   = 1'b1;
            code_d  = ErrTimeout;
            state_d = StIdle;
          end
`endif
        end
      end
      StDrain: begin
        if (sof_rcv) begin
          state_d = StActive;
          cnt_d   = 8'd0;
          phase_d = 2'd0;
`ifdef PPM_FRAME_TIMEOUT_EN
          tmo_d   = 16'd0;
`endif
        end else if (eof_rcv) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      phase_q  <= 2'd0;
      shift_q  <= 6'd0;
      dout_q   <= 8'd0;
      cnt_q    <= 8'd0;
      d_en_q   <= 1'b0;
      f_en_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
      f_pend_q <= 1'b0;
`ifdef PPM_FRAME_TIMEOUT_EN
      tmo_q    <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      shift_q  <= shift_d;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
      d_en_q   <= d_en_d;
      f_en_q   <= f_en_d;
      err_q    <= err_d;
      code_q   <= code_d;
      f_pend_q <= f_pend_d;
`ifdef PPM_FRAME_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign dec_en    = (state_q == StActive);
  assign Dout      = dout_q;
  assign D_en      = d_en_q;
  assign F_en      = f_en_q;
  assign byte_cnt  = cnt_q;
  assign frame_err = err_q;
  assign err_code  = code_q;

endmodule
